// File: rtl/alarm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alarm_pkg
//  Description : Shared state encoding and helpers for the alarm controller.
//  Revision    : 1.0  initial release
// ============================================================================
package alarm_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        DISARMED    = 3'd0,
        EXIT_DELAY  = 3'd1,
        ARMED       = 3'd2,
        ENTRY_DELAY = 3'd3,
        ALARM       = 3'd4
    } state_e;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alarm_timer.sv
`default_nettype none
// ============================================================================
//  Module      : alarm_timer
//  Description : Loadable down counter that holds at zero.
//  Revision    : 1.0  initial release
// ============================================================================
module alarm_timer #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] value,
    output logic             zero
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (count_q != '0) begin
            count_q <= count_q - WIDTH'(1);
        end
    end

    assign value = count_q;
    assign zero  = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/alarm_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : alarm_ctrl
//  Description : Intruder alarm FSM with exit/entry delays, siren and keypad lockout.
//  Revision    : 1.0  initial release
// ============================================================================
module alarm_ctrl
    import alarm_pkg::*;
#(
    parameter int                N_SENSORS    = 2,
    parameter int                CODE_W       = 5,
    parameter logic [CODE_W-1:0] ARM_CODE     = 5'b10000,
    parameter logic [CODE_W-1:0] DISARM_CODE  = 5'b00100,
    parameter int                EXIT_CYCLES  = 8,
    parameter int                ENTRY_CYCLES = 8,
    parameter int                SIREN_CYCLES = 32,
    parameter int                LOCK_CYCLES  = 16,
    parameter int                MAX_TRIES    = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_SENSORS-1:0] sensor,
    input  logic [N_SENSORS-1:0] zone_en,
    input  logic [CODE_W-1:0]    code,
    input  logic                 code_valid,
    output logic                 active,
    output logic                 alarm,
    output logic [STATE_W-1:0]   state,
    output logic                 locked
);

    localparam int MAX_DLY = max2(max2(EXIT_CYCLES, ENTRY_CYCLES), max2(SIREN_CYCLES, LOCK_CYCLES));
    localparam int TMR_W   = $clog2(MAX_DLY) + 1;
    localparam int BT_W    = $clog2(MAX_TRIES + 1);

    localparam logic [TMR_W-1:0] EXIT_LD  = TMR_W'(EXIT_CYCLES - 1);
    localparam logic [TMR_W-1:0] ENTRY_LD = TMR_W'(ENTRY_CYCLES - 1);
    localparam logic [TMR_W-1:0] SIREN_LD = TMR_W'(SIREN_CYCLES - 1);
    localparam logic [TMR_W-1:0] LOCK_LD  = TMR_W'(LOCK_CYCLES - 1);

    generate
        if (ARM_CODE == DISARM_CODE || EXIT_CYCLES < 1 || ENTRY_CYCLES < 1 ||
            SIREN_CYCLES < 1 || LOCK_CYCLES < 1 || MAX_TRIES < 1) begin : g_param_check
            $error("alarm_ctrl: codes must differ and all delays/tries must be >= 1");
        end
    endgenerate

    state_e            state_q, state_d;
    logic              active_q, alarm_q, locked_q;
    logic [BT_W-1:0]   tries_q, tries_d, tries_inc;
    logic              tmr_load, lock_load;
    logic [TMR_W-1:0]  tmr_ld_val, tmr_val, lock_val;
    logic              tmr_zero, lock_zero;
    logic              w_trip, w_acc, w_arm, w_disarm, w_wrong, w_lockout;
    logic              unused_ok;

    assign w_trip    = |(sensor & zone_en);
    assign w_acc     = code_valid & ~locked_q;
    assign w_arm     = w_acc & (code == ARM_CODE);
    assign w_disarm  = w_acc & (code == DISARM_CODE);
    assign w_wrong   = w_acc & ~w_arm & ~w_disarm;
    assign tries_inc = (tries_q == '1) ? tries_q : tries_q + BT_W'(1);
    assign w_lockout = w_wrong & (tries_inc >= BT_W'(MAX_TRIES));

    // Priority in armed states: disarm, then lockout, then timer/trip progress.
    always_comb begin
        state_d    = state_q;
        tries_d    = tries_q;
        tmr_load   = 1'b0;
        tmr_ld_val = '0;
        lock_load  = 1'b0;
        if (state_q == DISARMED) begin
            if (w_arm) begin
                state_d    = EXIT_DELAY;
                tmr_load   = 1'b1;
                tmr_ld_val = EXIT_LD;
            end
        end else if (w_disarm) begin
            state_d = DISARMED;
            tries_d = '0;
        end else if (w_lockout) begin
            state_d    = ALARM;
            tries_d    = '0;
            tmr_load   = 1'b1;
            tmr_ld_val = SIREN_LD;
            lock_load  = 1'b1;
        end else begin
            if (w_wrong) begin
                tries_d = tries_inc;
            end
            case (state_q)
                EXIT_DELAY: begin
                    if (tmr_zero) state_d = ARMED;
                end
                ARMED: begin
                    if (w_trip) begin
                        state_d    = ENTRY_DELAY;
                        tmr_load   = 1'b1;
                        tmr_ld_val = ENTRY_LD;
                    end
                end
                ENTRY_DELAY: begin
                    if (tmr_zero) begin
                        state_d    = ALARM;
                        tmr_load   = 1'b1;
                        tmr_ld_val = SIREN_LD;
                    end
                end
                ALARM: begin
                    if (tmr_zero) state_d = ARMED;
                end
                default: state_d = DISARMED;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= DISARMED;
            active_q <= 1'b0;
            alarm_q  <= 1'b0;
            locked_q <= 1'b0;
            tries_q  <= '0;
        end else begin
            state_q  <= state_d;
            active_q <= (state_d != DISARMED);
            alarm_q  <= (state_d == ALARM);
            tries_q  <= tries_d;
            if (lock_load) begin
                locked_q <= 1'b1;
            end else if (lock_zero) begin
                locked_q <= 1'b0;
            end
        end
    end

    alarm_timer #(.WIDTH(TMR_W)) u_fsm_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_ld_val),
        .value    (tmr_val),
        .zero     (tmr_zero)
    );

    alarm_timer #(.WIDTH(TMR_W)) u_lock_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (lock_load),
        .load_val (LOCK_LD),
        .value    (lock_val),
        .zero     (lock_zero)
    );

    assign unused_ok = ^{tmr_val, lock_val};

    assign active = active_q;
    assign alarm  = alarm_q;
    assign state  = state_q;
    assign locked = locked_q;

endmodule
`default_nettype wire

// File: tb/tb_alarm_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alarm_ctrl
//  Description : Directed plus randomized self-checking bench for alarm_ctrl.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alarm_ctrl;
    import alarm_pkg::*;

    localparam int          NS     = 2;
    localparam logic [4:0]  C_ARM  = 5'b10000;
    localparam logic [4:0]  C_DIS  = 5'b00100;
    localparam int          D_EXIT = 8;
    localparam int          D_ENT  = 8;
    localparam int          D_SIR  = 32;
    localparam int          D_LOCK = 16;
    localparam int          TRIES  = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NS-1:0] sensor = '0;
    logic [NS-1:0] zone_en = '0;
    logic [4:0]    code = '0;
    logic          code_valid = 1'b0;
    logic          active, alarm, locked;
    logic [2:0]    state;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: mode plus cycles spent in it, tries and lockout age.
    state_e m_mode;
    int     m_age, m_tries, m_lock_age;
    bit     m_locked;

    alarm_ctrl #(
        .N_SENSORS(NS), .CODE_W(5), .ARM_CODE(C_ARM), .DISARM_CODE(C_DIS),
        .EXIT_CYCLES(D_EXIT), .ENTRY_CYCLES(D_ENT), .SIREN_CYCLES(D_SIR),
        .LOCK_CYCLES(D_LOCK), .MAX_TRIES(TRIES)
    ) dut (
        .clk(clk), .rst(rst), .sensor(sensor), .zone_en(zone_en),
        .code(code), .code_valid(code_valid), .active(active),
        .alarm(alarm), .state(state), .locked(locked)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not end, observed running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = DISARMED; m_age = 0; m_tries = 0; m_locked = 0; m_lock_age = 0;
    endtask

    task automatic model_step();
        bit     trip, acc, arm, dis, wrong, restart;
        state_e nxt;
        trip  = |(sensor & zone_en);
        acc   = code_valid && !m_locked;
        arm   = acc && (code == C_ARM);
        dis   = acc && (code == C_DIS);
        wrong = acc && !arm && !dis;
        if (m_locked) begin
            m_lock_age++;
            if (m_lock_age >= D_LOCK) m_locked = 0;
        end
        nxt = m_mode;
        restart = 0;
        if (m_mode == DISARMED) begin
            if (arm) nxt = EXIT_DELAY;
        end else if (dis) begin
            nxt = DISARMED; m_tries = 0;
        end else if (wrong && m_tries + 1 >= TRIES) begin
            nxt = ALARM; restart = 1; m_tries = 0; m_locked = 1; m_lock_age = 0;
        end else begin
            if (wrong) m_tries++;
            if (m_mode == EXIT_DELAY && m_age + 1 >= D_EXIT) nxt = ARMED;
            if (m_mode == ARMED && trip) nxt = ENTRY_DELAY;
            if (m_mode == ENTRY_DELAY && m_age + 1 >= D_ENT) nxt = ALARM;
            if (m_mode == ALARM && m_age + 1 >= D_SIR) nxt = ARMED;
        end
        if (restart || nxt != m_mode) m_age = 0;
        else m_age++;
        m_mode = nxt;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".active"}, 32'(active), 32'(m_mode != DISARMED));
        chk({tag, ".alarm"},  32'(alarm),  32'(m_mode == ALARM));
        chk({tag, ".state"},  32'(state),  32'(m_mode));
        chk({tag, ".locked"}, 32'(locked), 32'(m_locked));
    endtask

    task automatic step(input logic [1:0] s, input logic [1:0] z, input logic v, input logic [4:0] c);
        sensor = s; zone_en = z; code_valid = v; code = c;
        @(posedge clk);
        model_step();
        #1;
        check_model("cyc");
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(2'b00, 2'b11, 1'b0, 5'd0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_model("reset");
        rst = 1'b0;

        // Arm; sensors during exit delay are ignored.
        step(2'b00, 2'b11, 1'b1, C_ARM);
        chk("arm_state", 32'(state), 32'(EXIT_DELAY));
        chk("arm_active", 32'(active), 32'd1);
        for (int i = 0; i < D_EXIT - 1; i++) step(2'b11, 2'b11, 1'b0, 5'd0);
        chk("exit_hold", 32'(state), 32'(EXIT_DELAY));
        idle(1);
        chk("armed", 32'(state), 32'(ARMED));

        // Trip, entry delay expires, siren, auto re-arm.
        step(2'b01, 2'b11, 1'b0, 5'd0);
        chk("entry", 32'(state), 32'(ENTRY_DELAY));
        idle(D_ENT);
        chk("siren_on", 32'(alarm), 32'd1);
        idle(D_SIR);
        chk("rearm_alarm", 32'(alarm), 32'd0);
        chk("rearm_state", 32'(state), 32'(ARMED));

        // Masked zone does not trip; then disarm.
        step(2'b10, 2'b01, 1'b0, 5'd0);
        chk("masked", 32'(state), 32'(ARMED));
        step(2'b10, 2'b01, 1'b1, C_DIS);
        chk("disarm_active", 32'(active), 32'd0);

        // Disarm on the same clock the entry timer expires.
        step(2'b00, 2'b11, 1'b1, C_ARM);
        idle(D_EXIT);
        step(2'b01, 2'b11, 1'b0, 5'd0);
        idle(D_ENT - 1);
        step(2'b01, 2'b11, 1'b1, C_DIS);
        chk("race_disarm", 32'(state), 32'(DISARMED));
        chk("race_alarm", 32'(alarm), 32'd0);

        // Three wrong codes force lockout; disarm ignored while locked.
        step(2'b00, 2'b11, 1'b1, C_ARM);
        idle(D_EXIT);
        step(2'b00, 2'b11, 1'b1, 5'b00001);
        step(2'b00, 2'b11, 1'b1, 5'b00010);
        step(2'b00, 2'b11, 1'b1, 5'b00011);
        chk("lock_alarm", 32'(alarm), 32'd1);
        chk("lock_locked", 32'(locked), 32'd1);
        step(2'b00, 2'b11, 1'b1, C_DIS);
        chk("lock_ignore", 32'(state), 32'(ALARM));
        idle(D_LOCK);
        chk("lock_over", 32'(locked), 32'd0);
        step(2'b00, 2'b11, 1'b1, C_DIS);
        chk("unlock_disarm", 32'(state), 32'(DISARMED));

        // Asynchronous reset in the middle of the siren.
        step(2'b00, 2'b11, 1'b1, C_ARM);
        idle(D_EXIT);
        step(2'b11, 2'b11, 1'b0, 5'd0);
        idle(D_ENT + 3);
        chk("pre_rst_alarm", 32'(alarm), 32'd1);
        #3 rst = 1'b1;
        #1;
        chk("async_alarm", 32'(alarm), 32'd0);
        chk("async_active", 32'(active), 32'd0);
        chk("async_state", 32'(state), 32'(DISARMED));
        model_reset();
        @(posedge clk);
        #1;
        check_model("rst_hold");
        rst = 1'b0;

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            logic [4:0] c;
            int         sel;
            sel = $urandom_range(0, 9);
            c = (sel < 4) ? C_ARM : (sel < 6) ? C_DIS : 5'($urandom);
            step(2'($urandom), 2'($urandom), ($urandom_range(0, 99) < 25), c);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alarm_ctrl.md
ALARM_CTRL -- requirements
Module: alarm_ctrl

Interface
REQ-001 Parameter N_SENSORS, default 2, number of sensor zones.
REQ-002 Parameter CODE_W, default 5, keypad code width.
REQ-003 Parameter ARM_CODE, default 5'b10000, arming code.
REQ-004 Parameter DISARM_CODE, default 5'b00100, disarming code; SHALL differ from ARM_CODE.
REQ-005 Parameters EXIT_CYCLES, ENTRY_CYCLES, SIREN_CYCLES, LOCK_CYCLES, defaults 8, 8, 32, 16, delay lengths in clocks, each >= 1.
REQ-006 Parameter MAX_TRIES, default 3, wrong codes before lockout.
REQ-007 clk  in  1  sole clock, rising edge.
REQ-008 rst  in  1  asynchronous, active-high reset.
REQ-009 sensor  in  N_SENSORS  per-zone motion/contact level, synchronous to clk.
REQ-010 zone_en  in  N_SENSORS  per-zone enable mask.
REQ-011 code  in  CODE_W  keypad value, sampled only when code_valid=1.
REQ-012 code_valid  in  1  single-cycle code-entry strobe.
REQ-013 active  out  1  system armed (any state except DISARMED).
REQ-014 alarm  out  1  siren drive.
REQ-015 state  out  3  current FSM state encoding.
REQ-016 locked  out  1  keypad lockout in progress.

Function
REQ-017 FSM states SHALL be DISARMED, EXIT_DELAY, ARMED, ENTRY_DELAY, ALARM; all outputs registered, updated one clock after the causing input.
REQ-018 trip = OR(sensor & zone_en); accepted code = code_valid & ~locked.
REQ-019 DISARMED: ARM_CODE -> EXIT_DELAY, timer loaded EXIT_CYCLES-1; all other codes and trips ignored.
REQ-020 EXIT_DELAY: trips ignored; DISARM_CODE -> DISARMED; timer==0 -> ARMED.
REQ-021 ARMED: DISARM_CODE -> DISARMED; else trip -> ENTRY_DELAY, timer loaded ENTRY_CYCLES-1.
REQ-022 ENTRY_DELAY: DISARM_CODE -> DISARMED; timer==0 -> ALARM, timer loaded SIREN_CYCLES-1; further trips do not restart timer.
REQ-023 ALARM: alarm=1; DISARM_CODE -> DISARMED; timer==0 -> ARMED (auto re-arm, alarm=0).
REQ-024 Simultaneous disarm with trip or timer expiry: disarm SHALL win.
REQ-025 ARM_CODE while not DISARMED: ignored, not counted as wrong.
REQ-026 Wrong code (neither ARM_CODE nor DISARM_CODE) in any armed state increments bad_tries (saturating); reaching MAX_TRIES SHALL force ALARM (siren timer loaded), assert locked for LOCK_CYCLES clocks, clear bad_tries.
REQ-027 While locked, code_valid SHALL be ignored entirely, including DISARM_CODE.
REQ-028 Successful disarm clears bad_tries.
REQ-029 Timers are down counters of width $clog2(max delay)+1; no wrap, hold at 0.

Reset
REQ-030 rst=1 SHALL immediately force DISARMED, active=0, alarm=0, locked=0, bad_tries=0, timers=0, including mid-delay or mid-alarm.
REQ-031 First transition permitted on the first rising clk after rst deasserts.

Structure
REQ-032 Package alarm_pkg SHALL hold the state enum and state encoding width.
REQ-033 One sub-module alarm_timer (loadable down counter, load/value/zero) instantiated for the FSM timer and lockout timer.
REQ-034 Elaboration-time check SHALL fail if ARM_CODE == DISARM_CODE or any delay parameter is 0.

Verification
REQ-035 Arm 10000 -> active=1 next clk, state EXIT_DELAY; sensor=2'b11 during exit delay -> no change; ARMED after 8 clks.
REQ-036 ARMED, sensor=2'b01, zone_en=2'b11 -> ENTRY_DELAY; no code for 8 clks -> alarm=1; after 32 more clks -> alarm=0, state ARMED.
REQ-037 ARMED, sensor=2'b10, zone_en=2'b01 -> stays ARMED; then disarm 00100 -> active=0.
REQ-038 ENTRY_DELAY, 00100 on the clk timer reaches 0 -> DISARMED, alarm never 1.
REQ-039 ARMED, codes 00001, 00010, 00011 -> alarm=1, locked=1; 00100 during 16-clk lockout ignored; 00100 after lockout -> DISARMED.
REQ-040 rst asserted mid-ALARM (between clk edges) -> alarm=0, active=0 without waiting for clk.
